pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match sequencer for the Pong game. Sits between the player buttons and the ball-dynamics engine, on the same `dyn_clk`. It drives the engine's reset (ball re-centre) and play (motion enable) controls, consumes the engine's one-cycle goal pulses, and keeps both scores. It also runs the serve / post-goal delays and declares the winner.

## Interface

Parameters:
- `WIN_SCORE`, default 5: score that ends the match; legal range 1..15.
- `SERVE_TICKS`, default 60: `dyn_clk` cycles spent in SERVE; legal range 1..255.
- `GOAL_TICKS`, default 30: `dyn_clk` cycles spent in GOAL (ball frozen after a goal); legal range 1..255.

Ports:
- `dyn_clk` in 1: dynamic (game-tick) clock; the only clock.
- `reset` in 1: synchronous, active-high; sampled on `posedge dyn_clk`.
- `btn_start` in 1: start/restart button, level, already debounced.
- `btn_pause` in 1: pause toggle button, level, already debounced.
- `goal_ply1` in 1: one-cycle pulse from the ball engine; point for player 1.
- `goal_ply2` in 1: one-cycle pulse from the ball engine; point for player 2.
- `game_reset` out 1: to the ball engine; high means hold the ball centred.
- `game_play` out 1: to the ball engine; high means the ball moves.
- `score_ply1` out 4: player 1 score, binary.
- `score_ply2` out 4: player 2 score, binary.
- `winner` out 2: 0 = none, 1 = player 1, 2 = player 2 (3 is never driven).
- `state` out 3: current FSM state encoding, for display/debug.

## Operation

- **Button edges.** Each button has a registered previous-value flop. Edge = `btn & ~btn_q`. Both `btn_q` flops reset to 1, so a button held through reset does not produce an edge.
- **Delay counter.** One 8-bit down-counter is shared by SERVE and GOAL. On entry to SERVE it is loaded with SERVE_TICKS-1; on entry to GOAL, with GOAL_TICKS-1. The state exits when the counter is 0, so each state lasts exactly N cycles.
- **FSM states and encodings:**
  - IDLE=0
  - SERVE=1
  - PLAY=2
  - PAUSE=3
  - GOAL=4
  - OVER=5
  - 6 and 7 are illegal and recover to IDLE.
- **IDLE.** Scores = 0, `winner` = 0. A start edge goes to SERVE.
- **SERVE.** The counter runs; exits to PLAY at 0. Pause and start edges are ignored.
- **PLAY.**
  - `goal_ply1` alone: `score_ply1` += 1. If the new value equals WIN_SCORE, go to OVER with `winner` = 1; otherwise go to GOAL.
  - `goal_ply2` is symmetric, with `winner` = 2.
  - Both goal pulses in the same cycle: no score change, stay in PLAY.
  - A pause edge goes to PAUSE. A goal pulse in the same cycle takes priority and the pause edge is dropped.
  - Start edge: ignored.
- **PAUSE.** A pause edge returns to PLAY. Goal pulses and start edges are ignored.
- **GOAL.** The counter runs; exits to SERVE at 0. Goal pulses are ignored.
- **OVER.** Scores and `winner` are held. A start edge clears the scores and `winner` and goes to SERVE.
- **Decoded outputs (Moore, from the state register):**
  - `game_reset` = 1 in IDLE and SERVE.
  - `game_play` = 1 only in PLAY.
- **Score arithmetic.** 4-bit. A score can never exceed WIN_SCORE, so no wrap is possible.

## Timing

- **Reset values:**
  - state = IDLE (`state` = 0)
  - `score_ply1` = `score_ply2` = 0
  - `winner` = 0
  - `game_reset` = 1, `game_play` = 0
  - counter = 0
  - `btn_q` = 1
- **Reset mid-operation** (any state, including mid-count) gives the reset values on the next edge. Reset has priority over every input.
- **Latencies:**
  - Button rising at edge t: edge detected in cycle t; state changes at edge t+1.
  - Goal pulse sampled at edge t: the score is updated and `game_play` = 0 after edge t+1.
  - SERVE entered at edge t: `game_play` rises after edge t+SERVE_TICKS.
- **Held buttons.** A button held high produces exactly one edge; the next action requires a release and a new press.
- **Counter.** Only decrements in SERVE and GOAL, and never underflows.

## Test plan

Bench parameters: WIN_SCORE=3, SERVE_TICKS=4, GOAL_TICKS=2.

1. Reset, then start pulse. Required: `state` goes 0→1; `game_reset` = 1 for exactly 4 cycles; then `state` = 2, `game_play` = 1, `game_reset` = 0.
2. In PLAY, pulse `goal_ply1`. Required: `score_ply1` = 1 and `state` = 4 one cycle later; 2 cycles in GOAL, 4 cycles in SERVE, back to PLAY.
3. Three `goal_ply2` pulses (each in PLAY). Required: `score_ply2` = 3, `state` = 5, `winner` = 2. A further goal pulse changes nothing. A start pulse then gives scores 0, `winner` 0, `state` 1.
4. In PLAY:
   - Pause pulse → `state` 3, `game_play` 0.
   - `goal_ply1` while in PAUSE → ignored, score unchanged.
   - Pause pulse → `state` 2.
   - `goal_ply1` and `goal_ply2` in the same cycle → scores unchanged, stays in PLAY.
   - Goal and pause edge in the same cycle → GOAL taken.
5. `btn_start` held high through the reset release. Required: stays in IDLE. Release and press again → SERVE.
6. Assert `reset` mid-SERVE and mid-GOAL with non-zero scores. Required: next cycle `state` 0, scores 0, `game_reset` 1, `game_play` 0.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/pause/goal/over flow, scores and winner,
// and the ball engine's re-centre / motion-enable controls.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned GOAL_TICKS  = 30
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       goal_ply1,
  input  logic       goal_ply2,
  output logic       game_reset,
  output logic       game_play,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned WIN_W   = 2;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   GOAL_LOAD  = CNT_W'(GOAL_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_GOAL  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [WIN_W-1:0]   winner_q, winner_d;
  logic               start_q, pause_q;
  logic               game_reset_q, game_play_q;

  logic               start_edge_c, pause_edge_c;
  logic [SCORE_W-1:0] score1_inc_c, score2_inc_c;

  assign start_edge_c = btn_start & ~start_q;
  assign pause_edge_c = btn_pause & ~pause_q;
  assign score1_inc_c = score1_q + SCORE_W'(1);
  assign score2_inc_c = score2_q + SCORE_W'(1);

  // State register plus button history; buttons reset high to mask held presses.
  always_ff @(posedge dyn_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= '0;
      start_q      <= 1'b1;
      pause_q      <= 1'b1;
      game_reset_q <= 1'b1;
      game_play_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      start_q      <= btn_start;
      pause_q      <= btn_pause;
      game_reset_q <= (state_d == ST_IDLE) || (state_d == ST_SERVE);
      game_play_q  <= (state_d == ST_PLAY);
    end
  end

  // Next-state, counter and score logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;

    case (state_q)
      ST_IDLE: begin
        score1_d = '0;
        score2_d = '0;
        winner_d = '0;
        if (start_edge_c) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      ST_SERVE: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_PLAY: begin
        // A lone goal wins over a pause edge; simultaneous goals cancel out.
        if (goal_ply1 && !goal_ply2) begin
          score1_d = score1_inc_c;
          if (score1_inc_c == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WIN_W'(1);
          end else begin
            state_d = ST_GOAL;
            cnt_d   = GOAL_LOAD;
          end
        end else if (goal_ply2 && !goal_ply1) begin
          score2_d = score2_inc_c;
          if (score2_inc_c == WIN_VAL) begin
            state_d  = ST_OVER;
            winner_d = WIN_W'(2);
          end else begin
            state_d = ST_GOAL;
            cnt_d   = GOAL_LOAD;
          end
        end else if (!goal_ply1 && !goal_ply2 && pause_edge_c) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (pause_edge_c) begin
          state_d = ST_PLAY;
        end
      end

      ST_GOAL: begin
        if (cnt_q == '0) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_OVER: begin
        if (start_edge_c) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = '0;
          state_d  = ST_SERVE;
          cnt_d    = SERVE_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state      = state_q;
  assign score_ply1 = score1_q;
  assign score_ply2 = score2_q;
  assign winner     = winner_q;
  assign game_reset = game_reset_q;
  assign game_play  = game_play_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: directed match scenarios then random play,
// checked every cycle against a phase/remaining-ticks reference model.
module tb_pong_match_ctrl;

  localparam int unsigned WIN = 3;
  localparam int unsigned SRV = 4;
  localparam int unsigned GL  = 2;

  logic       dyn_clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0, btn_pause = 1'b0;
  logic       goal_ply1 = 1'b0, goal_ply2 = 1'b0;
  logic       game_reset, game_play;
  logic [3:0] score_ply1, score_ply2;
  logic [1:0] winner;
  logic [2:0] state;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV), .GOAL_TICKS(GL)) dut (
    .dyn_clk(dyn_clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
    .goal_ply1(goal_ply1), .goal_ply2(goal_ply2), .game_reset(game_reset),
    .game_play(game_play), .score_ply1(score_ply1), .score_ply2(score_ply2),
    .winner(winner), .state(state)
  );

  always #5 dyn_clk = ~dyn_clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] w;
    logic       gr;
    logic       gp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phase number, cycles remaining in timed phases, scores.
  int ph = 0, left = 0, m1 = 0, m2 = 0, mw = 0;
  bit st_prev = 1'b1, pa_prev = 1'b1;

  function automatic void model_step(input bit r, input bit st, input bit pa,
                                     input bit g1, input bit g2);
    bit se, pe;
    if (r) begin
      ph = 0; left = 0; m1 = 0; m2 = 0; mw = 0;
      st_prev = 1'b1; pa_prev = 1'b1;
      return;
    end
    se = st && !st_prev;
    pe = pa && !pa_prev;
    st_prev = st;
    pa_prev = pa;
    case (ph)
      0: begin
        m1 = 0; m2 = 0; mw = 0;
        if (se) begin ph = 1; left = SRV; end
      end
      1: begin
        left = left - 1;
        if (left == 0) ph = 2;
      end
      2: begin
        if (g1 != g2) begin
          if (g1) m1 = m1 + 1; else m2 = m2 + 1;
          if ((g1 ? m1 : m2) == WIN) begin ph = 5; mw = g1 ? 1 : 2; end
          else begin ph = 4; left = GL; end
        end else if (!g1 && pe) begin
          ph = 3;
        end
      end
      3: if (pe) ph = 2;
      4: begin
        left = left - 1;
        if (left == 0) begin ph = 1; left = SRV; end
      end
      5: if (se) begin m1 = 0; m2 = 0; mw = 0; ph = 1; left = SRV; end
      default: ph = 0;
    endcase
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input bit r, input bit st, input bit pa, input bit g1, input bit g2);
    exp_t e;
    @(negedge dyn_clk);
    reset = r; btn_start = st; btn_pause = pa; goal_ply1 = g1; goal_ply2 = g2;
    model_step(r, st, pa, g1, g2);
    e.st = 3'(ph);
    e.s1 = 4'(m1);
    e.s2 = 4'(m2);
    e.w  = 2'(mw);
    e.gr = (ph == 0) || (ph == 1);
    e.gp = (ph == 2);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 40 && ph != target; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic press_start();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic press_pause();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle's outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge dyn_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (state !== e.st || score_ply1 !== e.s1 || score_ply2 !== e.s2 ||
            winner !== e.w || game_reset !== e.gr || game_play !== e.gp) begin
          n_err++;
          $display("FAIL outputs t=%0t: got st=%0d s1=%0d s2=%0d win=%0d rst=%0b play=%0b, want st=%0d s1=%0d s2=%0d win=%0d rst=%0b play=%0b",
                   $time, state, score_ply1, score_ply2, winner, game_reset, game_play,
                   e.st, e.s1, e.s2, e.w, e.gr, e.gp);
        end
      end
    end
  end

  initial begin
    bit r_st, r_pa;
    // Reset values and start into serve/play.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    press_start();
    run_until(2);
    idle(1);
    // Single point for player 1, then goal -> serve -> play.
    cyc(0, 0, 0, 1, 0);
    run_until(2);
    // Player 2 wins with three points.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (k < 2) run_until(2);
    end
    idle(2);
    cyc(0, 0, 0, 0, 1);
    idle(2);
    press_start();
    run_until(2);
    // Pause, ignored goal, resume, double goal, goal with pause edge.
    press_pause();
    cyc(0, 0, 0, 1, 0);
    idle(1);
    press_pause();
    cyc(0, 0, 0, 1, 1);
    idle(1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // Reset mid-serve with a non-zero score.
    run_until(1);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    idle(1);
    press_start();
    run_until(2);
    cyc(0, 0, 0, 0, 1);
    idle(1);
    // Reset mid-goal.
    cyc(1, 0, 0, 0, 0);
    idle(1);
    // Start held through reset release: no edge until released and pressed again.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    press_start();
    run_until(2);
    // Randomised play.
    r_st = 1'b0; r_pa = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) r_st = ~r_st;
      if ($urandom_range(0, 5) == 0) r_pa = ~r_pa;
      cyc(($urandom_range(0, 299) == 0), r_st, r_pa,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    idle(1);
    repeat (3) @(negedge dyn_clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
